// File: rtl/pe_operand_feeder_pkg.sv
// Shared definitions for the PE operand feeder.
// Holds the FSM state encoding, the default layer geometry with its derived
// constants, and helper functions that derive loop bounds and buffer address
// widths from module parameters.
package pe_operand_feeder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Output dimension of a stride-1, unpadded convolution.
  function automatic int out_dim(input int img, input int k);
    return img - k + 1;
  endfunction

  // Length of one accumulation group.
  function automatic int group_len(input int c_in, input int k);
    return c_in * k * k;
  endfunction

  function automatic int total_ops(input int img_w, input int img_h,
                                   input int c_in, input int k, input int n_filt);
    return out_dim(img_w, k) * out_dim(img_h, k) * n_filt * group_len(c_in, k);
  endfunction

  // Address width needed for a buffer of the given depth.
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Default layer geometry and its derived constants.
  localparam int DEF_IMG_W  = 32;
  localparam int DEF_IMG_H  = 32;
  localparam int DEF_C_IN   = 3;
  localparam int DEF_K      = 3;
  localparam int DEF_N_FILT = 3;
  localparam int OUT_W      = out_dim(DEF_IMG_W, DEF_K);
  localparam int OUT_H      = out_dim(DEF_IMG_H, DEF_K);
  localparam int G          = group_len(DEF_C_IN, DEF_K);
  localparam int TOTAL_OPS  = total_ops(DEF_IMG_W, DEF_IMG_H, DEF_C_IN, DEF_K, DEF_N_FILT);

endpackage

// File: rtl/pe_operand_feeder_skid_fifo.sv
// pe_skid_fifo: 2-entry register FIFO that absorbs buffer read latency so the
// operand stream can stall without losing in-flight data.
// Ports: clk, rst (async active-low), push/din (write), pop (read, only when
// count != 0), dout (head entry), count (0..2).
module pe_skid_fifo #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem;
  logic              wp, rp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem   <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rp];

endmodule

// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder: walks a 3x3 stride-1 unpadded convolution in im2col order
// (oy, ox, f, c, ky, kx), reading IFM and weight bytes from synchronous
// buffers and streaming (input_feature, weight) pairs to the PE with
// first/last tags marking each C_IN*K*K accumulation group.
// Ports: clk, rst (async active-low); start/busy/done control; ifm_rd_* and
// wgt_rd_* buffer read ports (data one cycle after enable); input_feature,
// weight, op_first, op_last with op_valid/op_ready handshake.
module pe_operand_feeder
  import pe_operand_feeder_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int C_IN   = 3,
  parameter int K      = 3,
  parameter int N_FILT = 3,
  parameter int DATA_W = 8,
  parameter int IFM_AW = 12,
  parameter int WGT_AW = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ifm_rd_en,
  output logic [IFM_AW-1:0] ifm_rd_addr,
  input  logic [DATA_W-1:0] ifm_rd_data,
  output logic              wgt_rd_en,
  output logic [WGT_AW-1:0] wgt_rd_addr,
  input  logic [DATA_W-1:0] wgt_rd_data,
  output logic [DATA_W-1:0] input_feature,
  output logic [DATA_W-1:0] weight,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              op_first,
  output logic              op_last
);

  localparam int OW = out_dim(IMG_W, K);
  localparam int OH = out_dim(IMG_H, K);
  localparam int CW = 16;
  localparam int FW = 2 + 2 * DATA_W;
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        state;
  logic [CW-1:0] oy, ox, f, c, ky, kx;
  logic          w_oy, w_ox, w_f, w_c, w_ky, w_kx, at_max;
  logic          issue, pop, inflight, first_d, last_d, first_i, last_i;
  logic [1:0]    occ;
  logic [2:0]    room;
  logic [FW-1:0] head;
  logic          head_first, head_last;

  assign w_kx   = (kx == CW'(K - 1));
  assign w_ky   = (ky == CW'(K - 1));
  assign w_c    = (c  == CW'(C_IN - 1));
  assign w_f    = (f  == CW'(N_FILT - 1));
  assign w_ox   = (ox == CW'(OW - 1));
  assign w_oy   = (oy == CW'(OH - 1));
  assign at_max = w_kx & w_ky & w_c & w_f & w_ox & w_oy;

  // Count of entries that will occupy the skid buffer after this cycle's pop,
  // including the read whose data returns this cycle. Issue only while that
  // leaves room, so the 2-entry buffer can never overflow under stall.
  assign pop   = op_valid & op_ready;
  assign room  = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign issue = (state == S_RUN) && (room < 3'd2);

  assign ifm_rd_en = issue;
  assign wgt_rd_en = issue;

  assign ifm_rd_addr = IFM_AW'(32'(c) * 32'(IMG_W * IMG_H)
                     + (32'(oy) + 32'(ky)) * 32'(IMG_W)
                     + 32'(ox) + 32'(kx));
  assign wgt_rd_addr = WGT_AW'(32'(f) * 32'(C_IN * K * K)
                     + 32'(c) * 32'(K * K)
                     + 32'(ky) * 32'(K) + 32'(kx));

  assign first_i = (c == '0) && (ky == '0) && (kx == '0);
  assign last_i  = w_c & w_ky & w_kx;

  // Control FSM; busy/done are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE:  if (start) begin
                   state <= S_RUN;
                   busy  <= 1'b1;
                 end
        S_RUN:   if (issue && at_max) state <= S_DRAIN;
        // Leave as the last pair hands off so done lands right after it.
        S_DRAIN: if (room == 3'd0) begin
                   state <= S_DONE;
                   done  <= 1'b1;
                 end
        S_DONE:  begin
                   state <= S_IDLE;
                   busy  <= 1'b0;
                 end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Loop counters (carry chain from kx outward) and read-return tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oy <= '0; ox <= '0; f <= '0; c <= '0; ky <= '0; kx <= '0;
      inflight <= 1'b0;
      first_d  <= 1'b0;
      last_d   <= 1'b0;
    end else begin
      inflight <= issue;
      first_d  <= first_i;
      last_d   <= last_i;
      if (issue) begin
        kx <= w_kx ? '0 : kx + ONE;
        if (w_kx)                         ky <= w_ky ? '0 : ky + ONE;
        if (w_kx & w_ky)                  c  <= w_c  ? '0 : c  + ONE;
        if (w_kx & w_ky & w_c)            f  <= w_f  ? '0 : f  + ONE;
        if (w_kx & w_ky & w_c & w_f)      ox <= w_ox ? '0 : ox + ONE;
        if (w_kx & w_ky & w_c & w_f & w_ox) oy <= w_oy ? '0 : oy + ONE;
      end
    end
  end

  pe_skid_fifo #(.W(FW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .din   ({first_d, last_d, wgt_rd_data, ifm_rd_data}),
    .dout  (head),
    .count (occ)
  );

  assign {head_first, head_last, weight, input_feature} = head;
  assign op_valid = (occ != 2'd0);
  assign op_first = head_first & op_valid;
  assign op_last  = head_last & op_valid;

endmodule
